// File: rtl/spi_slave_if.sv
// Signal bundle between the SPI pins / local logic and the spi_slave target.
// The slave modport is the target's view; master is the view of whatever
// drives the pins and the transmit load port.
interface spi_slave_if #(
    parameter int unsigned DWIDTH = 8
);
    logic              ss;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [DWIDTH-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DWIDTH-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  ss, sclk, mosi, tx_data, tx_load,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output ss, sclk, mosi, tx_data, tx_load,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI target. Oversamples sclk/ss/mosi on clk, shifts words MSB-first
// in both directions, hands received words out with a one-cycle valid pulse
// and takes the next transmit word from a single-entry load buffer.
module spi_slave #(
    parameter int unsigned DWIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    spi_slave_if.slave  bus
);

    localparam int unsigned     CNT_W    = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DWIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e            state_q, state_d;

    logic [2:0]        sclk_sync_q;
    logic [1:0]        ss_sync_q;
    logic [1:0]        mosi_sync_q;

    logic [DWIDTH-1:0] shift_tx_q, shift_tx_d;
    logic [DWIDTH-1:0] shift_rx_q, shift_rx_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DWIDTH-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic [DWIDTH-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;

    logic              ss_s;
    logic              mosi_s;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              word_start;
    logic [DWIDTH-1:0] rx_next;
    logic              busy;
    logic              miso;

    assign ss_s      = ss_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];

    // Two-flop synchronizers for the pins, plus a third sclk stage for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], bus.sclk};
            ss_sync_q   <= {ss_sync_q[0], bus.ss};
            mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: selection alone decides between IDLE and ACTIVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_s)  state_d = ACTIVE;
            ACTIVE:  if (!ss_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy while ACTIVE, miso forced low when not selected.
    always_comb begin
        busy = (state_q == ACTIVE);
        miso = busy ? shift_tx_q[DWIDTH-1] : 1'b0;
    end

    // Datapath next state: shifting, word completion, word start and load buffer.
    // A deselect suppresses any edge seen in the same cycle, so partial words are dropped.
    always_comb begin
        shift_tx_d    = shift_tx_q;
        shift_rx_d    = shift_rx_q;
        bit_cnt_d     = bit_cnt_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        word_start    = 1'b0;
        rx_next       = {shift_rx_q[DWIDTH-2:0], mosi_s};

        case (state_q)
            IDLE: begin
                if (ss_s) word_start = 1'b1;
            end
            ACTIVE: begin
                if (ss_s) begin
                    if (sclk_rise) begin
                        shift_rx_d = rx_next;
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            word_start = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else if (sclk_fall && (bit_cnt_q != '0)) begin
                        // bit_cnt of 0 means a fresh word whose MSB must stay on the line.
                        shift_tx_d = shift_tx_q << 1;
                    end
                end
            end
            default: ;
        endcase

        if (word_start) begin
            shift_tx_d    = tx_full_q ? tx_buf_q : '0;
            tx_underrun_d = ~tx_full_q;
            tx_full_d     = 1'b0;
            bit_cnt_d     = '0;
        end

        // A load coinciding with a word start refills the buffer just emptied.
        if (bus.tx_load && (!tx_full_q || word_start)) begin
            tx_buf_d  = bus.tx_data;
            tx_full_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_tx_q    <= '0;
            shift_rx_q    <= '0;
            bit_cnt_q     <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
        end else begin
            shift_tx_q    <= shift_tx_d;
            shift_rx_q    <= shift_rx_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
        end
    end

    assign bus.miso        = miso;
    assign bus.busy        = busy;
    assign bus.tx_ready    = ~tx_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave (DWIDTH = 8): acts as SPI master at sclk = clk/10
// and as local logic on the load port.
module tb_spi_slave;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_slave_if #(.DWIDTH(8)) bus ();

    spi_slave #(.DWIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int urun_cnt = 0;

    // Count output pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1)    rx_cnt++;
        if (bus.tx_underrun === 1'b1) urun_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
    endtask

    // Mode 0 master: present mosi in the low phase, sample miso just before the rise.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.mosi = mo[i];
            tick(5);
            mi[i] = bus.miso;
            bus.sclk = 1'b1;
            tick(5);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        bus.ss = 1'b1;
        tick(6);
    endtask

    task automatic frame_end();
        tick(4);
        bus.ss = 1'b0;
        tick(8);
    endtask

    initial begin
        logic [7:0] mi;
        int r0;
        int u0;

        reset       = 1'b0;
        bus.ss      = 1'b0;
        bus.sclk    = 1'b0;
        bus.mosi    = 1'b0;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);

        // Reset state
        check("rst_busy",     bus.busy,        0);
        check("rst_miso",     bus.miso,        0);
        check("rst_tx_ready", bus.tx_ready,    1);
        check("rst_rx_valid", bus.rx_valid,    0);
        check("rst_rx_data",  bus.rx_data,     0);
        check("rst_underrun", bus.tx_underrun, 0);

        // Basic exchange: slave sends 0x3C, master sends 0xA5
        load(8'h3C);
        check("basic_tx_ready_full", bus.tx_ready, 0);
        r0 = rx_cnt;
        u0 = urun_cnt;
        frame_start();
        check("basic_busy",          bus.busy, 1);
        check("basic_tx_ready_back", bus.tx_ready, 1);
        check("basic_no_underrun",   urun_cnt - u0, 0);
        xfer(8'hA5, 8, mi);
        check("basic_miso", mi, 8'h3C);
        frame_end();
        check("basic_rx_pulses", rx_cnt - r0, 1);
        check("basic_rx_data",   bus.rx_data, 8'hA5);
        check("basic_idle",      bus.busy, 0);

        // Back-to-back: 0x81, 0x7E out; 0x12, 0x34 in
        load(8'h81);
        r0 = rx_cnt;
        u0 = urun_cnt;
        frame_start();
        check("b2b_tx_ready", bus.tx_ready, 1);
        load(8'h7E);
        xfer(8'h12, 8, mi);
        check("b2b_miso0",       mi, 8'h81);
        check("b2b_rx_pulses0",  rx_cnt - r0, 1);
        check("b2b_rx_data0",    bus.rx_data, 8'h12);
        check("b2b_no_underrun", urun_cnt - u0, 0);
        xfer(8'h34, 8, mi);
        check("b2b_miso1", mi, 8'h7E);
        frame_end();
        check("b2b_rx_pulses1", rx_cnt - r0, 2);
        check("b2b_rx_data1",   bus.rx_data, 8'h34);

        // Load collision: second load while full is dropped
        load(8'h11);
        load(8'h22);
        check("coll_tx_ready_full", bus.tx_ready, 0);
        frame_start();
        check("coll_second_dropped", bus.tx_ready, 1);
        xfer(8'h00, 8, mi);
        check("coll_miso", mi, 8'h11);
        frame_end();
        check("coll_rx_data", bus.rx_data, 8'h00);

        // Underrun: nothing loaded
        u0 = urun_cnt;
        r0 = rx_cnt;
        frame_start();
        check("urun_pulse_once", urun_cnt - u0, 1);
        xfer(8'hC7, 8, mi);
        check("urun_miso_zero", mi, 8'h00);
        frame_end();
        check("urun_rx_pulses", rx_cnt - r0, 1);
        check("urun_rx_data",   bus.rx_data, 8'hC7);

        // Abort after 3 bits, then a clean 0x5A frame
        r0 = rx_cnt;
        frame_start();
        xfer(8'hFF, 3, mi);
        bus.ss = 1'b0;
        tick(8);
        check("abort_no_rx_valid", rx_cnt - r0, 0);
        check("abort_rx_kept",     bus.rx_data, 8'hC7);
        check("abort_idle",        bus.busy, 0);
        frame_start();
        xfer(8'h5A, 8, mi);
        frame_end();
        check("abort_next_pulses", rx_cnt - r0, 1);
        check("abort_next_rx",     bus.rx_data, 8'h5A);

        // Reset mid-frame after 4 bits, with the buffer full
        frame_start();
        load(8'h99);
        check("mrst_tx_full", bus.tx_ready, 0);
        xfer(8'hFF, 4, mi);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("mrst_busy",     bus.busy,        0);
        check("mrst_miso",     bus.miso,        0);
        check("mrst_rx_data",  bus.rx_data,     0);
        check("mrst_rx_valid", bus.rx_valid,    0);
        check("mrst_underrun", bus.tx_underrun, 0);
        check("mrst_tx_ready", bus.tx_ready,    1);
        bus.ss = 1'b0;
        tick(8);
        r0 = rx_cnt;
        load(8'h66);
        frame_start();
        xfer(8'hC3, 8, mi);
        check("mrst_next_miso", mi, 8'h66);
        frame_end();
        check("mrst_next_pulses", rx_cnt - r0, 1);
        check("mrst_next_rx",     bus.rx_data, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
